lcd_write_sched: RTL and testbench

LCD_WRITE_SCHED -- requirements
Module: lcd_write_sched

---
 rtl/lcd_write_sched.sv | 165 ++++++++++++++++
 tb/tb_lcd_write_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_sched.sv
// Purpose: HD44780 4-bit write scheduler: power-up/init sequence, then round-robin byte writes from two requesters.
// Latency: grant one edge after a request seen in IDLE; a byte occupies 2*E_CYC+GAP_CYC+settle+1 cycles.
// Backpressure: requests are held until gnt; no gnt is issued outside IDLE.
module lcd_write_sched #(
    parameter int E_CYC      = 800,
    parameter int GAP_CYC    = 20,
    parameter int WAIT_SHORT = 800,
    parameter int WAIT_LONG  = 60000,
    parameter int PWRUP_CYC  = 300000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_data,
    output logic       busy,
    output logic       init_done
);
    localparam logic [19:0] E_LD  = 20'(E_CYC - 1);
    localparam logic [19:0] G_LD  = 20'(GAP_CYC - 1);
    localparam logic [19:0] WS_LD = 20'(WAIT_SHORT - 1);
    localparam logic [19:0] WL_LD = 20'(WAIT_LONG - 1);
    localparam logic [19:0] PW_LD = 20'(PWRUP_CYC - 1);

    typedef enum logic [2:0] {PWRUP, INIT_E, INIT_W, IDLE, HI_E, GAP, LO_E, SETTLE} state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  nib_q, nib_d;
    logic [7:0]  byte_q, byte_d;
    logic        prio_q, prio_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        lcd_rs_q, lcd_rs_d, lcd_e_q, lcd_e_d;
    logic [3:0]  lcd_data_q, lcd_data_d;
    logic        busy_q, busy_d, init_done_q, init_done_d;
    logic        cnt_done, pick1, slow_cmd;

    assign cnt_done = (cnt_q == 20'd0);
    // prio_q=1 gives req1 precedence when both requesters are waiting
    assign pick1    = req1 & (~req0 | prio_q);
    // clear display / return home need the long settle time
    assign slow_cmd = ~lcd_rs_q & (byte_q[7:2] == 6'd0) & (byte_q[1:0] != 2'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_done ? cnt_q : cnt_q - 20'd1;
        nib_d       = nib_q;
        byte_d      = byte_q;
        prio_d      = prio_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        lcd_rs_d    = lcd_rs_q;
        lcd_e_d     = lcd_e_q;
        lcd_data_d  = lcd_data_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        case (state_q)
            PWRUP: if (cnt_done) begin
                state_d    = INIT_E;
                cnt_d      = E_LD;
                nib_d      = 2'd0;
                lcd_rs_d   = 1'b0;
                lcd_e_d    = 1'b1;
                lcd_data_d = 4'h3;
            end
            INIT_E: if (cnt_done) begin
                state_d = INIT_W;
                cnt_d   = WL_LD;
                lcd_e_d = 1'b0;
            end
            INIT_W: if (cnt_done) begin
                if (nib_q == 2'd3) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    init_done_d = 1'b1;
                end else begin
                    state_d    = INIT_E;
                    cnt_d      = E_LD;
                    nib_d      = nib_q + 2'd1;
                    lcd_e_d    = 1'b1;
                    lcd_data_d = (nib_q == 2'd2) ? 4'h2 : 4'h3;
                end
            end
            IDLE: if (req0 | req1) begin
                state_d    = HI_E;
                cnt_d      = E_LD;
                gnt0_d     = ~pick1;
                gnt1_d     = pick1;
                prio_d     = ~pick1;
                byte_d     = pick1 ? data1 : data0;
                lcd_rs_d   = pick1 ? rs1 : rs0;
                lcd_data_d = pick1 ? data1[7:4] : data0[7:4];
                lcd_e_d    = 1'b1;
                busy_d     = 1'b1;
            end
            HI_E: if (cnt_done) begin
                state_d = GAP;
                cnt_d   = G_LD;
                lcd_e_d = 1'b0;
            end
            GAP: if (cnt_done) begin
                state_d    = LO_E;
                cnt_d      = E_LD;
                lcd_e_d    = 1'b1;
                lcd_data_d = byte_q[3:0];
            end
            LO_E: if (cnt_done) begin
                state_d = SETTLE;
                cnt_d   = slow_cmd ? WL_LD : WS_LD;
                lcd_e_d = 1'b0;
            end
            SETTLE: if (cnt_done) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWRUP;
            cnt_q       <= PW_LD;
            nib_q       <= 2'd0;
            byte_q      <= 8'd0;
            prio_q      <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_data_q  <= 4'd0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nib_q       <= nib_d;
            byte_q      <= byte_d;
            prio_q      <= prio_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_e_q     <= lcd_e_d;
            lcd_data_q  <= lcd_data_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_data  = lcd_data_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
endmodule

// File: tb/tb_lcd_write_sched.sv
// Bench for lcd_write_sched: timeline model of init and byte writes, random two-requester traffic.
module tb_lcd_write_sched;
    localparam int E = 4, G = 2, WS = 3, WL = 10, PW = 5;
    localparam int N = 4096;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'd0, data1 = 8'd0;
    logic       gnt0, gnt1, lcd_rs, lcd_e, busy, init_done;
    logic [3:0] lcd_data;

    always #5 clk = ~clk;

    lcd_write_sched #(.E_CYC(E), .GAP_CYC(G), .WAIT_SHORT(WS), .WAIT_LONG(WL), .PWRUP_CYC(PW)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1), .lcd_rs(lcd_rs),
        .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy), .init_done(init_done)
    );

    int n_checks = 0, n_fail = 0;
    // observed/expected layout: {e, rs, data[3:0], busy, gnt0, gnt1, init_done}
    logic [9:0] obs;
    assign obs = {lcd_e, lcd_rs, lcd_data, busy, gnt0, gnt1, init_done};
    logic [9:0] exp_v [N];
    int         cyc, next_free, prio;
    logic [3:0] last_d;
    logic       last_rs;
    logic       pend [2];
    logic       prs [2];
    logic [7:0] pd [2];

    task automatic model_start();
        cyc = 0;
        next_free = 0;
        for (int i = 0; i < N; i++) exp_v[i] = {1'b0, last_rs, last_d, 4'b0001};
    endtask

    // A byte granted at cycle k: hi nibble strobe, gap, lo nibble strobe, settle, then idle holding the bus.
    function automatic void model_grant(int k, int w);
        int s;
        s = (!prs[w] && pd[w] >= 8'd1 && pd[w] <= 8'd3) ? WL : WS;
        for (int i = k; i < N; i++) begin
            int j;
            logic e;
            logic [3:0] d;
            j = i - k;
            e = (j < E) || (j >= E + G && j < 2 * E + G);
            d = (j < E + G) ? pd[w][7:4] : pd[w][3:0];
            exp_v[i] = {e, prs[w], d, (j < 2 * E + G + s), (j == 0 && w == 0), (j == 0 && w == 1), 1'b1};
        end
        next_free = k + 2 * E + G + s + 1;
        last_d = pd[w][3:0];
        last_rs = prs[w];
    endfunction

    task automatic tb_cycle();
        int w;
        cyc++;
        req0 = pend[0]; rs0 = prs[0]; data0 = pd[0];
        req1 = pend[1]; rs1 = prs[1]; data1 = pd[1];
        if (cyc >= next_free && (pend[0] || pend[1])) begin
            w = (pend[0] && pend[1]) ? prio : (pend[0] ? 0 : 1);
            model_grant(cyc, w);
            prio = 1 - w;
            pend[w] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] rv;
        rv = {1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (obs !== rv) begin
                n_fail++;
                $display("FAIL reset_state got e,rs,d,busy,g0,g1,done=%b required %b", obs, rv);
            end
            n_checks++;
        end
    endtask

    // Expects rst_n low on entry; releases it and follows PWRUP plus the four init nibbles.
    task automatic test_init(input bit with_reqs);
        logic [9:0] ev;
        int n, off;
        logic e;
        req0 = with_reqs; req1 = with_reqs; rs0 = 1'b0; rs1 = 1'b1; data0 = 8'h36; data1 = 8'h44;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= PW + 4 * (E + WL); j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j < PW) begin
                ev = {1'b0, 1'b0, 4'h0, 4'b1000};
            end else begin
                n = (j - PW) / (E + WL);
                if (n > 3) n = 3;
                off = (j - PW) - n * (E + WL);
                e = (off < E) && (j < PW + 4 * (E + WL));
                ev = {e, 1'b0, (n == 3) ? 4'h2 : 4'h3, (j < PW + 4 * (E + WL)), 2'b00, (j >= PW + 4 * (E + WL))};
            end
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL init j=%0d reqs=%0d got %b required %b", j, with_reqs, obs, ev);
            end
            n_checks++;
        end
        if (with_reqs) begin
            @(posedge clk);
            @(negedge clk);
            if ({gnt0, gnt1} !== 2'b10) begin
                n_fail++;
                $display("FAIL first_grant_after_init got g0g1=%b required 10", {gnt0, gnt1});
            end
            n_checks++;
        end
        req0 = 1'b0; req1 = 1'b0;
        prio = 0; last_d = 4'h2; last_rs = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
    endtask

    task automatic test_single_write();
        model_start();
        pend[0] = 1'b1; prs[0] = 1'b1; pd[0] = 8'h41;
        while ((pend[0] || cyc < next_free) && cyc < N - 1) begin
            tb_cycle();
            if (obs !== exp_v[cyc]) begin
                n_fail++;
                $display("FAIL single_write cyc=%0d got %b required %b", cyc, obs, exp_v[cyc]);
            end
            n_checks++;
        end
    endtask

    task automatic test_settle();
        int         who [4] = '{1, 1, 0, 1};
        logic       rsv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] dv  [4] = '{8'h01, 8'h0C, 8'h03, 8'h02};
        model_start();
        for (int t = 0; t < 4; t++) begin
            pend[who[t]] = 1'b1; prs[who[t]] = rsv[t]; pd[who[t]] = dv[t];
            while ((pend[who[t]] || cyc < next_free) && cyc < N - 1) begin
                tb_cycle();
                if (obs !== exp_v[cyc]) begin
                    n_fail++;
                    $display("FAIL settle byte=%h cyc=%0d got %b required %b", dv[t], cyc, obs, exp_v[cyc]);
                end
                n_checks++;
            end
        end
    endtask

    task automatic test_back_to_back();
        model_start();
        for (int c = 0; c < 120; c++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i]) begin
                    pend[i] = 1'b1; prs[i] = 1'($urandom_range(0, 1)); pd[i] = 8'($urandom);
                end
            tb_cycle();
            if (obs !== exp_v[cyc]) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got %b required %b", cyc, obs, exp_v[cyc]);
            end
            n_checks++;
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        while (cyc < next_free && cyc < N - 1) begin
            tb_cycle();
            if (obs !== exp_v[cyc]) begin
                n_fail++;
                $display("FAIL back_to_back_drain cyc=%0d got %b required %b", cyc, obs, exp_v[cyc]);
            end
            n_checks++;
        end
    endtask

    task automatic test_random();
        model_start();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b1;
                    prs[i] = ($urandom_range(0, 2) != 0);
                    if ($urandom_range(0, 1) == 1) pd[i] = 8'($urandom_range(0, 4));
                    else pd[i] = 8'($urandom);
                end else if (pend[i] && $urandom_range(0, 99) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            tb_cycle();
            if (obs !== exp_v[cyc]) begin
                n_fail++;
                $display("FAIL random cyc=%0d got %b required %b", cyc, obs, exp_v[cyc]);
            end
            n_checks++;
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        while (cyc < next_free && cyc < N - 1) begin
            tb_cycle();
            if (obs !== exp_v[cyc]) begin
                n_fail++;
                $display("FAIL random_drain cyc=%0d got %b required %b", cyc, obs, exp_v[cyc]);
            end
            n_checks++;
        end
    endtask

    task automatic test_reset_mid_byte();
        model_start();
        pend[0] = 1'b1; prs[0] = 1'b1; pd[0] = 8'hA5;
        for (int c = 0; c < E + G + 2; c++) begin
            tb_cycle();
            if (obs !== exp_v[cyc]) begin
                n_fail++;
                $display("FAIL mid_byte_pre cyc=%0d got %b required %b", cyc, obs, exp_v[cyc]);
            end
            n_checks++;
        end
        #2 rst_n = 1'b0;
        #1;
        if ({lcd_e, gnt0, gnt1, busy, init_done, lcd_data} !== 9'b0_0_0_1_0_0000) begin
            n_fail++;
            $display("FAIL async_reset_mid_byte got e,g0,g1,busy,done,d=%b required 000100000",
                     {lcd_e, gnt0, gnt1, busy, init_done, lcd_data});
        end
        n_checks++;
        test_init(1'b0);
        model_start();
        for (int c = 0; c < 30; c++) begin
            tb_cycle();
            if (obs !== exp_v[cyc]) begin
                n_fail++;
                $display("FAIL no_resend cyc=%0d got %b required %b", cyc, obs, exp_v[cyc]);
            end
            n_checks++;
        end
    endtask

    task automatic test_req_during_init();
        rst_n = 1'b0;
        @(negedge clk);
        test_init(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        prs[0] = 1'b0; prs[1] = 1'b0; pd[0] = 8'd0; pd[1] = 8'd0;
        prio = 0; last_d = 4'h2; last_rs = 1'b0;
        test_reset();
        test_init(1'b0);
        test_single_write();
        test_settle();
        test_back_to_back();
        test_random();
        test_reset_mid_byte();
        test_req_during_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
